fatori_fi_sequencer: RTL

Drives the fault-injection side of the FATORI fault-tolerance fabric. It accepts injection commands and drives the 8-bit `fi_port` target select for a programmed hold window. It also emits the register-injection pulse, then watches the aggregated minor/major detection pulses to classify and time each injection. Results are returned on a valid/ready response channel to the campaign controller. It sits beside the fault manager, feeding the `fi_port` and injection-pulse inputs that the fault manager consumes.

---
 rtl/fatori_fi_sequencer_if.sv | 46 ++++
 rtl/fatori_fi_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fatori_fi_sequencer_if.sv
// Command / injection / detection / response bundle of the FATORI fault-injection sequencer.
// With FATORI_FI_STATS_EN defined the bundle also carries the four event counters.
interface fatori_fi_sequencer_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_target_i;
  logic [15:0] cmd_delay_i;
  logic [7:0]  cmd_hold_i;
  logic        abort_i;
  logic [7:0]  fi_port_o;
  logic        reg_injection_pulse_o;
  logic        detect_min_i;
  logic        detect_maj_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_status_o;
  logic [15:0] rsp_latency_o;
`ifdef FATORI_FI_STATS_EN
  logic [15:0] stat_inj_cnt_o;
  logic [15:0] stat_det_cnt_o;
  logic [15:0] stat_to_cnt_o;
  logic [15:0] stat_spurious_cnt_o;
`endif

  // Sequencer side
  modport slave (
    input  cmd_valid_i, cmd_target_i, cmd_delay_i, cmd_hold_i, abort_i,
           detect_min_i, detect_maj_i, rsp_ready_i,
    output cmd_ready_o, fi_port_o, reg_injection_pulse_o,
           rsp_valid_o, rsp_status_o, rsp_latency_o
`ifdef FATORI_FI_STATS_EN
         , stat_inj_cnt_o, stat_det_cnt_o, stat_to_cnt_o, stat_spurious_cnt_o
`endif
  );

  // Campaign controller / fabric side
  modport master (
    output cmd_valid_i, cmd_target_i, cmd_delay_i, cmd_hold_i, abort_i,
           detect_min_i, detect_maj_i, rsp_ready_i,
    input  cmd_ready_o, fi_port_o, reg_injection_pulse_o,
           rsp_valid_o, rsp_status_o, rsp_latency_o
`ifdef FATORI_FI_STATS_EN
         , stat_inj_cnt_o, stat_det_cnt_o, stat_to_cnt_o, stat_spurious_cnt_o
`endif
  );
endinterface

// File: rtl/fatori_fi_sequencer.sv
// FATORI fault-injection sequencer: delay, drive fi_port for a hold window, classify detection.
// Optional event counters are enabled with the FATORI_FI_STATS_EN macro.
module fatori_fi_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  fatori_fi_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_INJECT,
    S_OBSERVE,
    S_REPORT
  } state_t;

  localparam logic [1:0]      ST_MINOR   = 2'd0;
  localparam logic [1:0]      ST_MAJOR   = 2'd1;
  localparam logic [1:0]      ST_TIMEOUT = 2'd2;
  localparam logic [1:0]      ST_BADTGT  = 2'd3;
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_reg;
  logic [7:0]      target_reg;
  logic [7:0]      hold_reg;
  logic [7:0]      hold_cnt_reg;
  logic [15:0]     delay_cnt_reg;
  logic [15:0]     lat_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            cmd_ready_reg;
  logic            pulse_reg;
  logic [7:0]      fi_port_reg;
  logic            rsp_valid_reg;
  logic [1:0]      rsp_status_reg;
  logic [15:0]     rsp_latency_reg;

  logic        cmd_fire;
  logic        detect;
  logic        active;
  logic [1:0]  det_status;
  logic [15:0] lat_next;
  logic [7:0]  hold_eff;
  logic        inj_start;
  logic [7:0]  inj_target;
  logic [7:0]  inj_hold;
  logic        det_rsp;
  logic        to_rsp;

  assign cmd_fire   = bus.cmd_valid_i & cmd_ready_reg;
  assign detect     = bus.detect_min_i | bus.detect_maj_i;
  assign active     = (state_reg == S_INJECT) || (state_reg == S_OBSERVE);
  assign det_status = bus.detect_maj_i ? ST_MAJOR : ST_MINOR;
  assign lat_next   = (lat_reg == 16'hFFFF) ? lat_reg : lat_reg + 16'd1;
  assign hold_eff   = (bus.cmd_hold_i == 8'd0) ? 8'd1 : bus.cmd_hold_i;

  // Injection begins either straight from an accepted zero-delay command or at the end of DELAY.
  assign inj_start  = ((state_reg == S_IDLE) && cmd_fire && (bus.cmd_target_i != 8'd0) &&
                       (bus.cmd_delay_i == 16'd0)) ||
                      ((state_reg == S_DELAY) && !bus.abort_i && (delay_cnt_reg == 16'd1));
  assign inj_target = (state_reg == S_IDLE) ? bus.cmd_target_i : target_reg;
  assign inj_hold   = (state_reg == S_IDLE) ? hold_eff : hold_reg;
  assign det_rsp    = active && !bus.abort_i && detect;
  assign to_rsp     = (state_reg == S_OBSERVE) && !bus.abort_i && !detect &&
                      (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= S_IDLE;
      target_reg      <= 8'd0;
      hold_reg        <= 8'd0;
      hold_cnt_reg    <= 8'd0;
      delay_cnt_reg   <= 16'd0;
      lat_reg         <= 16'd0;
      to_cnt_reg      <= '0;
      cmd_ready_reg   <= 1'b1;
      pulse_reg       <= 1'b0;
      fi_port_reg     <= 8'd0;
      rsp_valid_reg   <= 1'b0;
      rsp_status_reg  <= 2'd0;
      rsp_latency_reg <= 16'd0;
    end else begin
      pulse_reg <= 1'b0;
      if (inj_start) begin
        state_reg     <= S_INJECT;
        cmd_ready_reg <= 1'b0;
        fi_port_reg   <= inj_target;
        pulse_reg     <= 1'b1;
        lat_reg       <= 16'd0;
        hold_cnt_reg  <= inj_hold;
      end else if (bus.abort_i && (state_reg != S_IDLE)) begin
        state_reg     <= S_IDLE;
        cmd_ready_reg <= 1'b1;
        fi_port_reg   <= 8'd0;
        rsp_valid_reg <= 1'b0;
      end else if (det_rsp) begin
        state_reg       <= S_REPORT;
        fi_port_reg     <= 8'd0;
        rsp_valid_reg   <= 1'b1;
        rsp_status_reg  <= det_status;
        rsp_latency_reg <= lat_reg;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (cmd_fire) begin
              target_reg    <= bus.cmd_target_i;
              hold_reg      <= hold_eff;
              cmd_ready_reg <= 1'b0;
              if (bus.cmd_target_i == 8'd0) begin
                state_reg       <= S_REPORT;
                rsp_valid_reg   <= 1'b1;
                rsp_status_reg  <= ST_BADTGT;
                rsp_latency_reg <= 16'd0;
              end else begin
                state_reg     <= S_DELAY;
                delay_cnt_reg <= bus.cmd_delay_i;
              end
            end
          end
          S_DELAY: begin
            delay_cnt_reg <= delay_cnt_reg - 16'd1;
          end
          S_INJECT: begin
            lat_reg <= lat_next;
            if (hold_cnt_reg == 8'd1) begin
              state_reg   <= S_OBSERVE;
              fi_port_reg <= 8'd0;
              to_cnt_reg  <= '0;
            end else begin
              hold_cnt_reg <= hold_cnt_reg - 8'd1;
            end
          end
          S_OBSERVE: begin
            lat_reg <= lat_next;
            if (to_rsp) begin
              state_reg       <= S_REPORT;
              rsp_valid_reg   <= 1'b1;
              rsp_status_reg  <= ST_TIMEOUT;
              rsp_latency_reg <= 16'hFFFF;
            end else begin
              to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
          end
          S_REPORT: begin
            if (bus.rsp_ready_i) begin
              state_reg     <= S_IDLE;
              rsp_valid_reg <= 1'b0;
              cmd_ready_reg <= 1'b1;
            end
          end
          default: begin
            state_reg     <= S_IDLE;
            cmd_ready_reg <= 1'b1;
            fi_port_reg   <= 8'd0;
            rsp_valid_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cmd_ready_o           = cmd_ready_reg;
  assign bus.fi_port_o             = fi_port_reg;
  assign bus.reg_injection_pulse_o = pulse_reg;
  assign bus.rsp_valid_o           = rsp_valid_reg;
  assign bus.rsp_status_o          = rsp_status_reg;
  assign bus.rsp_latency_o         = rsp_latency_reg;

`ifdef FATORI_FI_STATS_EN
  logic             spurious;
  logic [3:0]       stat_inc;
  logic [3:0][15:0] stat_cnt;

  assign spurious = detect && ((state_reg == S_IDLE) || (state_reg == S_DELAY) ||
                               (state_reg == S_REPORT));
  assign stat_inc = {spurious, to_rsp, det_rsp, inj_start};

  // Counters tick on the event itself, so an aborted command keeps what it already produced.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_reg <= 16'd0;
      end else if (stat_inc[gi]) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
    assign stat_cnt[gi] = cnt_reg;
  end

  assign bus.stat_inj_cnt_o      = stat_cnt[0];
  assign bus.stat_det_cnt_o      = stat_cnt[1];
  assign bus.stat_to_cnt_o       = stat_cnt[2];
  assign bus.stat_spurious_cnt_o = stat_cnt[3];
`endif

endmodule
